// File: rtl/ucsbece154b_dmem_arbiter.sv
// ucsbece154b_dmem_arbiter
// Serialises the two M-stage data-memory requests of a dual-issue pipeline
// onto one single-ported, variable-latency backing memory. Lane 1 (older) is
// always served first. A lane-2 load that hits a lane-1 store to the same word
// can be forwarded, which skips the second access. The pipeline is stalled
// while the bundle is in flight. It is then released for exactly one cycle
// (DONE), during which both read results are valid.
module ucsbece154b_dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req1_i,
    input  logic              req2_i,
    input  logic              we1_i,
    input  logic              we2_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [DATA_W-1:0] wdata2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    logic   w_fwd;

    // A lane-2 load reads the same word that the lane-1 store writes, so the
    // store data is already the answer.
    assign w_fwd = (FWD_EN != 0) && req2_i && !we2_i && we1_i &&
                   (addr1_i[ADDR_W-1:2] == addr2_i[ADDR_W-1:2]);

    // Hold the pipeline whenever a bundle is present and has not reached DONE.
    // This is combinational, so a new bundle stalls in its first IDLE cycle.
    assign stall_o = (req1_i | req2_i) && (r_state != DONE);

    // Sequencer: state, registered memory-port drive and captured read data.
    // NOTE: the reset is asynchronous, so an abandoned access drops mem_req_o
    // immediately. Only the control and data registers are cleared; no memory
    // array lives here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata1_o    <= '0;
            rdata2_o    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register update from
            // the pre-edge state, independent of statement order.
            case (r_state)
                IDLE: begin
                    if (req1_i) begin
                        r_state     <= ACC1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= we1_i;
                        mem_addr_o  <= addr1_i;
                        mem_wdata_o <= wdata1_i;
                    end else if (req2_i) begin
                        r_state     <= ACC2;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= we2_i;
                        mem_addr_o  <= addr2_i;
                        mem_wdata_o <= wdata2_i;
                    end
                end
                ACC1: begin
                    if (mem_ack_i) begin
                        if (!we1_i) begin
                            rdata1_o <= mem_rdata_i;
                        end
                        if (w_fwd) begin
                            rdata2_o  <= wdata1_i;
                            r_state   <= DONE;
                            mem_req_o <= 1'b0;
                        end else if (req2_i) begin
                            // Keep the request asserted and retarget it to lane 2.
                            r_state     <= ACC2;
                            mem_we_o    <= we2_i;
                            mem_addr_o  <= addr2_i;
                            mem_wdata_o <= wdata2_i;
                        end else begin
                            r_state   <= DONE;
                            mem_req_o <= 1'b0;
                        end
                    end
                end
                ACC2: begin
                    if (mem_ack_i) begin
                        if (!we2_i) begin
                            rdata2_o <= mem_rdata_i;
                        end
                        r_state   <= DONE;
                        mem_req_o <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_dmem_arbiter.sv
// Testbench for ucsbece154b_dmem_arbiter.
// Two instances share the clock and reset: u[0] has forwarding enabled and
// u[1] has it disabled. A behavioural memory responder serves each instance
// with a configurable number of wait cycles. A bundle-level reference model
// predicts the access list, read results, stall length and memory contents.
module tb_ucsbece154b_dmem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic reset;

    logic        req1 [2];
    logic        req2 [2];
    logic        we1 [2];
    logic        we2 [2];
    logic [31:0] addr1 [2];
    logic [31:0] addr2 [2];
    logic [31:0] wdata1 [2];
    logic [31:0] wdata2 [2];
    logic [31:0] rdata1 [2];
    logic [31:0] rdata2 [2];
    logic        stall [2];
    logic        mem_req [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic        mem_ack [2] = '{1'b0, 1'b0};
    logic [31:0] mem_rdata [2] = '{32'h0, 32'h0};

    // Responder state. Only the responder process writes these.
    logic [31:0] dmem [2][256];
    bit          written [2][256];
    int          cnt [2] = '{0, 0};
    acc_t        log_a [2][512];
    int          log_n [2] = '{0, 0};

    // Written only by the stimulus process.
    int          wait_cfg [2];
    bit          inject [2];
    logic [31:0] mmem [2][256];
    logic [31:0] exp_rd1 [2];
    logic [31:0] exp_rd2 [2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ucsbece154b_dmem_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .FWD_EN((g == 0) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req1_i     (req1[g]),
            .req2_i     (req2[g]),
            .we1_i      (we1[g]),
            .we2_i      (we2[g]),
            .addr1_i    (addr1[g]),
            .addr2_i    (addr2[g]),
            .wdata1_i   (wdata1[g]),
            .wdata2_i   (wdata2[g]),
            .rdata1_o   (rdata1[g]),
            .rdata2_o   (rdata2[g]),
            .stall_o    (stall[g]),
            .mem_req_o  (mem_req[g]),
            .mem_we_o   (mem_we[g]),
            .mem_addr_o (mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_ack_i  (mem_ack[g]),
            .mem_rdata_i(mem_rdata[g])
        );
    end

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 'h40) return 32'hDEAD_BEEF;
        if (idx == 'h81) return 32'h0000_0022;
        return 32'h1000_0000 + 32'(idx) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] rd_word(input int d, input int idx);
        return written[d][idx] ? dmem[d][idx] : init_val(idx);
    endfunction

    // Memory responder. Each access is acknowledged after wait_cfg[g] wait
    // cycles with a one-cycle pulse. Every accepted access is logged.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int idx;
            mem_ack[g] = 1'b0;
            if (!reset) begin
                cnt[g] = 0;
            end else if (mem_req[g]) begin
                if (cnt[g] >= wait_cfg[g]) begin
                    idx = int'(mem_addr[g][9:2]);
                    mem_ack[g]   = 1'b1;
                    cnt[g]       = 0;
                    mem_rdata[g] = rd_word(g, idx);
                    if (mem_we[g]) begin
                        dmem[g][idx]    = mem_wdata[g];
                        written[g][idx] = 1'b1;
                    end
                    if (log_n[g] < 512) begin
                        log_a[g][log_n[g]].we    = mem_we[g];
                        log_a[g][log_n[g]].addr  = mem_addr[g];
                        log_a[g][log_n[g]].wdata = mem_wdata[g];
                        log_n[g]++;
                    end
                end else begin
                    cnt[g]++;
                end
            end else begin
                cnt[g] = 0;
            end
            if (inject[g]) begin
                mem_ack[g]   = 1'b1;
                mem_rdata[g] = 32'h5A5A_5A5A;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drives one bundle into instance d and holds it until DONE. The result
    // is then compared against the bundle-level model.
    task automatic run_bundle(input int d,
                              input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                              input bit r2, input bit w2, input logic [31:0] a2, input logic [31:0] d2,
                              input int wt, input string tag);
        acc_t        eq[$];
        acc_t        e;
        bit          fwd;
        bit          done;
        int          cyc;
        int          start;
        int          exp_stall;
        logic [31:0] e1;
        logic [31:0] e2;
        int          ia1;
        int          ia2;

        // Model: lane 1 then lane 2, with forwarding on instance 0 only.
        e1  = exp_rd1[d];
        e2  = exp_rd2[d];
        ia1 = int'(a1[9:2]);
        ia2 = int'(a2[9:2]);
        fwd = (d == 0) && r1 && w1 && r2 && !w2 && (a1[31:2] == a2[31:2]);
        if (r1) begin
            e.we = w1; e.addr = a1; e.wdata = d1;
            eq.push_back(e);
            if (w1) mmem[d][ia1] = d1;
            else    e1 = mmem[d][ia1];
        end
        if (r2) begin
            if (fwd) begin
                e2 = d1;
            end else begin
                e.we = w2; e.addr = a2; e.wdata = d2;
                eq.push_back(e);
                if (w2) mmem[d][ia2] = d2;
                else    e2 = mmem[d][ia2];
            end
        end
        exp_stall = 1 + eq.size() * (wt + 1);

        @(negedge clk);
        wait_cfg[d] = wt;
        start       = log_n[d];
        req1[d] = r1; we1[d] = w1; addr1[d] = a1; wdata1[d] = d1;
        req2[d] = r2; we2[d] = w2; addr2[d] = a2; wdata2[d] = d2;

        cyc  = 0;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!stall[d]) begin
                done = 1'b1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $error("FAIL %s_timeout: stall still high after 200 cycles, want low", tag);
        end

        check({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_stall));
        check({tag, "_rdata1"}, rdata1[d], e1);
        check({tag, "_rdata2"}, rdata2[d], e2);
        check({tag, "_mem_req_done"}, 32'(mem_req[d]), 32'd0);
        check({tag, "_n_access"}, 32'(log_n[d] - start), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++) begin
            if (start + i < log_n[d]) begin
                check($sformatf("%s_acc%0d_we", tag, i), 32'(log_a[d][start + i].we), 32'(eq[i].we));
                check($sformatf("%s_acc%0d_addr", tag, i), log_a[d][start + i].addr, eq[i].addr);
                if (eq[i].we) begin
                    check($sformatf("%s_acc%0d_wdata", tag, i), log_a[d][start + i].wdata, eq[i].wdata);
                end
            end
        end

        req1[d] = 1'b0;
        req2[d] = 1'b0;
        @(negedge clk);
        exp_rd1[d] = e1;
        exp_rd2[d] = e2;
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req1[d] = 1'b0; req2[d] = 1'b0; we1[d] = 1'b0; we2[d] = 1'b0;
            addr1[d] = '0; addr2[d] = '0; wdata1[d] = '0; wdata2[d] = '0;
            wait_cfg[d] = 0; inject[d] = 1'b0;
            exp_rd1[d] = '0; exp_rd2[d] = '0;
            for (int i = 0; i < 256; i++) mmem[d][i] = init_val(i);
        end

        // Reset held with a pending lane-1 load.
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 32'h40;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req[0]), 32'd0);
        check("rst_mem_we", 32'(mem_we[0]), 32'd0);
        check("rst_mem_addr", mem_addr[0], 32'h0);
        check("rst_rdata1", rdata1[0], 32'h0);
        check("rst_rdata2", rdata2[0], 32'h0);
        check("rst_stall", 32'(stall[0]), 32'd1);
        check("rst_stall_idle", 32'(stall[1]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rel_mem_req", 32'(mem_req[0]), 32'd1);
        check("rel_mem_addr", mem_addr[0], 32'h40);
        @(negedge clk);
        #1;
        check("rel_stall_done", 32'(stall[0]), 32'd0);
        check("rel_rdata1", rdata1[0], init_val('h10));
        exp_rd1[0] = init_val('h10);
        req1[0] = 1'b0;
        @(negedge clk);

        // Directed bundles.
        run_bundle(0, 1, 0, 32'h100, 32'h0,    0, 0, 32'h0,   32'h0,    2, "ld1_wait2");
        run_bundle(0, 1, 1, 32'h200, 32'h11,   1, 0, 32'h204, 32'h0,    0, "st_ld_diff");
        run_bundle(0, 1, 1, 32'h300, 32'hCAFE, 1, 0, 32'h300, 32'h0,    0, "fwd_on");
        run_bundle(1, 1, 1, 32'h300, 32'hCAFE, 1, 0, 32'h300, 32'h0,    0, "fwd_off");
        run_bundle(0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h104, 32'h0,    1, "ld2_only");
        run_bundle(0, 1, 1, 32'h20,  32'hAAAA, 1, 1, 32'h20,  32'hBBBB, 0, "st_st_same0");
        run_bundle(1, 1, 1, 32'h20,  32'hAAAA, 1, 1, 32'h20,  32'hBBBB, 1, "st_st_same1");
        run_bundle(1, 1, 0, 32'h24,  32'h0,    1, 0, 32'h28,  32'h0,    3, "ld_ld_wait3");

        // Random bundles on small address pools so same-word pairs occur.
        for (int n = 0; n < 60; n++) begin
            bit          r1;
            bit          r2;
            logic [31:0] a1;
            logic [31:0] a2;
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            if (!r1 && !r2) r1 = 1'b1;
            a1 = 32'($urandom_range(0, 7)) << 2;
            a2 = 32'($urandom_range(0, 7)) << 2;
            run_bundle(n % 2, r1, 1'($urandom_range(0, 1)), a1, $urandom,
                       r2, 1'($urandom_range(0, 1)), a2, $urandom,
                       int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        // Final backing-memory contents must match the model for both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                check($sformatf("mem%0d_w%0d", d, i), rd_word(d, i), mmem[d][i]);
            end
        end

        // Reset during an ACC2 wait, then a stray ack after release.
        @(negedge clk);
        wait_cfg[0] = 20;
        req2[0] = 1'b1; we2[0] = 1'b0; addr2[0] = 32'h10;
        @(negedge clk);
        #1;
        check("acc2_mem_req", 32'(mem_req[0]), 32'd1);
        check("acc2_mem_addr", mem_addr[0], 32'h10);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req[0]), 32'd0);
        check("midrst_stall", 32'(stall[0]), 32'd1);
        check("midrst_rdata1", rdata1[0], 32'h0);
        check("midrst_rdata2", rdata2[0], 32'h0);
        req2[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        inject[0] = 1'b1;
        inject[1] = 1'b1;
        @(negedge clk);
        #2;
        inject[0] = 1'b0;
        inject[1] = 1'b0;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("stray%0d_rdata1", d), rdata1[d], 32'h0);
            check($sformatf("stray%0d_rdata2", d), rdata2[d], 32'h0);
            check($sformatf("stray%0d_mem_req", d), 32'(mem_req[d]), 32'd0);
            check($sformatf("stray%0d_stall", d), 32'(stall[d]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_dmem_arbiter.md
# ucsbece154b_dmem_arbiter

Sequences the two M-stage data-memory requests of the dual-issue pipeline onto one single-ported, variable-latency backing memory (SDRAM controller side). Lane 1 (older instruction) is always served before lane 2. A store→load forwarding path lets a lane-2 load that hits a lane-1 store skip its own access. While the bundle is being served, the block stalls the whole pipeline, then releases it for exactly one cycle with both read results valid.

## Interface
Parameters:
- ADDR_W, 32, address width of lane and memory ports
- DATA_W, 32, data width
- FWD_EN, 1, enable lane-1-store → lane-2-load forwarding (0 = always perform both accesses)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req1_i / req2_i  in  1  lane 1/2 M-stage memory op valid (load or store)
- we1_i / we2_i  in  1  lane 1/2 store (1) or load (0)
- addr1_i / addr2_i  in  ADDR_W  lane 1/2 byte address (word aligned)
- wdata1_i / wdata2_i  in  DATA_W  lane 1/2 store data
- rdata1_o / rdata2_o  out  DATA_W  lane 1/2 load result (registered)
- stall_o  out  1  freeze the pipeline; lane inputs held stable while 1
- mem_req_o  out  1  backing-memory request (registered)
- mem_we_o  out  1  backing-memory write enable (registered)
- mem_addr_o  out  ADDR_W  backing-memory address (registered)
- mem_wdata_o  out  DATA_W  backing-memory write data (registered)
- mem_ack_i  in  1  one-cycle completion pulse; mem_rdata_i valid in the same cycle
- mem_rdata_i  in  DATA_W  backing-memory read data

## Operation
- FSM states: IDLE, ACC1, ACC2, DONE.
- IDLE: if req1_i, go to ACC1 and load the mem_* registers with lane 1. Otherwise, if req2_i, go to ACC2 and load the mem_* registers with lane 2. Otherwise stay in IDLE.
- ACC1: mem_req_o=1; hold the mem_* registers until mem_ack_i.
  - On ack with we1_i=0: rdata1_o ← mem_rdata_i.
  - Forwarding applies when FWD_EN=1, req2_i=1, we2_i=0, we1_i=1 and addr1_i[ADDR_W-1:2]==addr2_i[ADDR_W-1:2]. In that case rdata2_o ← wdata1_i and the FSM goes to DONE.
  - Otherwise, if req2_i, go to ACC2 with the mem_* registers loaded from lane 2.
  - Otherwise go to DONE.
- ACC2: mem_req_o=1 until mem_ack_i. On ack with we2_i=0, rdata2_o ← mem_rdata_i. Then go to DONE.
- DONE: stall_o=0, the pipeline advances, and the FSM returns unconditionally to IDLE.
- stall_o = (req1_i | req2_i) & (state != DONE). This is combinational, so a new bundle stalls in its first IDLE cycle.
- mem_req_o falls in the same clock edge that moves the FSM out of ACC1/ACC2 to DONE/IDLE. Between ACC1 and ACC2 it stays 1 with the new address.
- Two stores to the same word: both are issued in order, so lane 2's data is the final memory value.
- rdata1_o/rdata2_o hold their value until the next capture. They are not updated for stores or for absent lanes.
- mem_ack_i received in IDLE or DONE is ignored.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata1_o=0, rdata2_o=0. stall_o then follows the req inputs (1 if any req).
- Reset mid-access drops mem_req_o immediately. The memory side must tolerate an abandoned request.
- Single-lane bundle, ack in first ACC cycle: stall_o high for 2 cycles (IDLE, ACC), low in DONE. Total 3 cycles.
- Two-lane bundle, ack in first cycle of each: stall_o high for 3 cycles. Forwarded pair: 2 cycles.
- Ack after N wait cycles adds N stall cycles per access.
- rdata*_o are valid from the edge that leaves the ACC state, so they are stable throughout DONE.
- Back-to-back bundles: DONE → IDLE → ACC. There is one IDLE cycle minimum between accesses of consecutive bundles.

## Test plan
1. Reset: hold reset=0 with req1_i=1 → mem_req_o=0, rdata*_o=0, stall_o=1. Release reset → ACC1 next cycle with mem_addr_o=addr1_i.
2. Lane-1 load only: addr1=0x100, mem returns 0xDEADBEEF with ack after 2 wait cycles → stall_o high 4 cycles. rdata1_o=0xDEADBEEF in DONE. mem_req_o low in DONE.
3. Dual access, store then load to different words: st 0x200←0x11, ld 0x204 returns 0x22 → two mem_req phases in order, second with mem_we_o=0. rdata2_o=0x22.
4. Forwarding: st 0x300←0xCAFE, ld 0x300. With FWD_EN=1 → one memory access, rdata2_o=0xCAFE, stall 2 cycles. With FWD_EN=0 → two accesses, rdata2_o=memory value.
5. Lane-2-only load (req1_i=0): FSM IDLE→ACC2. rdata1_o unchanged, rdata2_o captured.
6. Reset asserted during ACC2 wait → mem_req_o=0 asynchronously, state IDLE. A stray mem_ack_i after reset release → ignored, rdata*_o stay 0.
